combo_sequencer: RTL and testbench
==================================

Name: combo_sequencer

Overview:
- Initiator side of the button-combo handshake: accepts a 2-bit combo command and drives the b[3:1] inputs of the combo-detector FSM with exact cycle timing.
- Optionally monitors the detector's outp line against the expected waveform and reports pass/fail per frame.
- Sits between a test/command source (valid/ready) and the detector; used for self-test and scripted stimulus.

Parameters:
- GAP_CYCLES, 1, number of cycles b is held at 3'b000 after each frame before the next command is accepted (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock, shared with the detector FSM
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_code  input  2  00=B1 (b=3'b001), 01=B3B1 (3'b101), 10=B2 (3'b010), 11=B3B2 (3'b110)
- cmd_ready  output  1  high only in IDLE; the command is taken on the edge where cmd_valid && cmd_ready
- b  output  3  registered drive to the detector's b[3:1]
- outp_in  input  1  detector outp, looped back
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at the end of each frame
- rsp_err  output  1  valid with done; 1 = outp mismatch during the frame

Behaviour:
- Reset values: b=3'b000, busy=0, done=0, rsp_err=0, state=IDLE. The reset is asynchronous and can land mid-frame; the block returns to IDLE and drops b to 0 immediately. The detector has its own reset.
- cmd_ready is combinational from state (IDLE). No handshake can complete while rst is high.
- States: IDLE, F0, F1, F2, F3, TAIL, GAP. Cycle numbering: F0 is cycle k, the first cycle b carries the code.
- IDLE: on accept, register b=code pattern and go to F0. Latency is 1 cycle from the accepting edge to b valid.
- F0 to F3 (k..k+3): b holds the code, steady for all 4 cycles. The detector samples b in its idle state at k, uses b[3] at k+2 and branches on b[2] at k+3.
- Long frames (b[2]=1): F3 goes to TAIL. TAIL spans k+4..k+7 with b=0 and a 2-bit counter.
- Short frames: F3 goes directly to GAP at k+4.
- GAP: b=0 for GAP_CYCLES cycles, then IDLE.
- done and rsp_err pulse on the first GAP cycle: k+4 for short frames, k+8 for long frames.
- Expected outp waveform: k and k+1 are 0; k+2 equals code b[3]; k+3 is 1; k+4..k+7 are 0 (long frames only).
- Mismatch handling: a sticky per-frame error flag is set on any mismatch and cleared on accept.
- b is never nonzero outside F0 to F3. This prevents the detector from retriggering during its return to idle.
- cmd_valid while busy is ignored: no queueing, and cmd_code is not sampled.
- Minimum command-to-command spacing: 4+GAP_CYCLES+1 cycles for short frames, 8+GAP_CYCLES+1 for long frames.

Optional Feature:
- Macro: COMBO_SEQUENCER_CHECK_EN.
- Defined: outp_in is compared per cycle as above and rsp_err reports the result.
- Undefined: outp_in is unused, no comparison logic or error flag is synthesised, and rsp_err is tied to 0. done timing is unchanged.

Decomposition:
- Package combo_pkg holds:
  - the cmd_code encodings and their b patterns (B1, B3B1, B2, B3B2)
  - the state encoding (one-hot, 7 states)
  - SHORT_FRAME_LEN=4 and LONG_FRAME_LEN=8
- One sub-module, combo_outp_checker: takes the frame cycle index, the code and outp_in, and produces the sticky error. It is instantiated only under COMBO_SEQUENCER_CHECK_EN.

Test Plan:
- Reset, then cmd_code=00 with valid held for 1 cycle. Expect: b=001 for exactly cycles k..k+3, then 000; done at k+4 with rsp_err=0; detector outp = 0,0,0,1.
- cmd_code=11. Expect: b=110 for 4 cycles; outp = 0,0,1,1,0,0,0,0; done at k+8 with rsp_err=0; cmd_ready returns at k+8+GAP_CYCLES.
- Back-to-back valid with codes 01 then 10, GAP_CYCLES=1. Expect: second accept at k+5, no detector retrigger, two done pulses, both rsp_err=0.
- Force outp_in=0 at k+3 of a code 00 frame. Expect: done at k+4 with rsp_err=1; the next clean frame reports rsp_err=0.
- Assert rst at k+2 of a code 11 frame. Expect: b=000 and busy=0 immediately, no done pulse; after release the next command completes normally.
- Build without COMBO_SEQUENCER_CHECK_EN and rerun the forced-mismatch case. Expect: done timing identical, rsp_err=0.

Source files
------------

// File: rtl/combo_sequencer_pkg.sv
// Shared encodings for the combo sequencer: command codes, b patterns, FSM states.
package combo_pkg;

  typedef enum logic [1:0] {
    CMD_B1   = 2'b00,
    CMD_B3B1 = 2'b01,
    CMD_B2   = 2'b10,
    CMD_B3B2 = 2'b11
  } cmd_code_e;

  localparam logic [3:1] PAT_B1   = 3'b001;
  localparam logic [3:1] PAT_B3B1 = 3'b101;
  localparam logic [3:1] PAT_B2   = 3'b010;
  localparam logic [3:1] PAT_B3B2 = 3'b110;

  localparam int unsigned SHORT_FRAME_LEN = 4;
  localparam int unsigned LONG_FRAME_LEN  = 8;

  typedef enum logic [6:0] {
    ST_IDLE = 7'b000_0001,
    ST_F0   = 7'b000_0010,
    ST_F1   = 7'b000_0100,
    ST_F2   = 7'b000_1000,
    ST_F3   = 7'b001_0000,
    ST_TAIL = 7'b010_0000,
    ST_GAP  = 7'b100_0000
  } state_e;

  function automatic logic [3:1] code_to_b(input cmd_code_e code);
    case (code)
      CMD_B1:   return PAT_B1;
      CMD_B3B1: return PAT_B3B1;
      CMD_B2:   return PAT_B2;
      default:  return PAT_B3B2;
    endcase
  endfunction

endpackage

// File: rtl/combo_sequencer_if.sv
// Command/response and detector-drive bundle between a command source and combo_sequencer.
interface combo_sequencer_if;

  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic [3:1] b;
  logic       outp_in;
  logic       busy;
  logic       done;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_code, outp_in,
    input  cmd_ready, b, busy, done, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_code, outp_in,
    output cmd_ready, b, busy, done, rsp_err
  );

endinterface

// File: rtl/combo_outp_checker.sv
// Compares the detector's outp against the expected per-frame waveform; sticky error.
module combo_outp_checker
  import combo_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_active,
  input  logic      i_clear,
  input  logic [2:0] i_idx,
  input  cmd_code_e i_code,
  input  logic      i_outp,
  output logic      o_err
);

  logic [3:1] w_pattern;
  logic       w_exp;
  logic       w_mismatch;
  logic       r_err;

  assign w_pattern = code_to_b(i_code);

  // Cycle k+2 mirrors b[3], k+3 is the detection pulse, every other frame cycle is low.
  always_comb begin
    w_exp = 1'b0;
    case (i_idx)
      3'd2:    w_exp = w_pattern[3];
      3'd3:    w_exp = 1'b1;
      default: w_exp = 1'b0;
    endcase
  end

  assign w_mismatch = i_active && (i_outp != w_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_err <= 1'b0;
    else if (i_clear)    r_err <= 1'b0;
    else if (w_mismatch) r_err <= 1'b1;
  end

  assign o_err = r_err;

endmodule

// File: rtl/combo_sequencer.sv
// Drives detector b[3:1] frames from valid/ready commands; optional outp checking
// is enabled with the COMBO_SEQUENCER_CHECK_EN macro.
module combo_sequencer
  import combo_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  combo_sequencer_if.slave  bus
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e     r_state, w_state_nxt;
  cmd_code_e  r_code, w_code_nxt;
  logic [3:1] r_b, w_b_nxt;
  logic [1:0] r_tail_cnt, w_tail_nxt;
  logic [3:0] r_gap_cnt, w_gap_nxt;
  logic [3:1] w_pattern;
  logic       w_accept;
  logic       w_done;

  assign w_pattern = code_to_b(r_code);
  assign w_accept  = bus.cmd_valid && (r_state == ST_IDLE);

  // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_b_nxt     = 3'b000;
    w_tail_nxt  = r_tail_cnt;
    w_gap_nxt   = r_gap_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_F0;
          w_code_nxt  = cmd_code_e'(bus.cmd_code);
          w_b_nxt     = code_to_b(cmd_code_e'(bus.cmd_code));
        end
      end
      ST_F0: begin
        w_state_nxt = ST_F1;
        w_b_nxt     = w_pattern;
      end
      ST_F1: begin
        w_state_nxt = ST_F2;
        w_b_nxt     = w_pattern;
      end
      ST_F2: begin
        w_state_nxt = ST_F3;
        w_b_nxt     = w_pattern;
      end
      ST_F3: begin
        // The detector branches on b[2]: long frames need four more quiet cycles.
        if (w_pattern[2]) begin
          w_state_nxt = ST_TAIL;
          w_tail_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = 4'd0;
        end
      end
      ST_TAIL: begin
        w_tail_nxt = r_tail_cnt + 2'd1;
        if (r_tail_cnt == 2'd3) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = 4'd0;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
        else                       w_gap_nxt   = r_gap_cnt + 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_code     <= CMD_B1;
      r_b        <= 3'b000;
      r_tail_cnt <= 2'd0;
      r_gap_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_b        <= w_b_nxt;
      r_tail_cnt <= w_tail_nxt;
      r_gap_cnt  <= w_gap_nxt;
    end
  end

  assign w_done        = (r_state == ST_GAP) && (r_gap_cnt == 4'd0);
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.b         = r_b;
  assign bus.done      = w_done;

`ifdef COMBO_SEQUENCER_CHECK_EN
  logic       w_active;
  logic [2:0] w_idx;
  logic       w_err;

  assign w_active = (r_state == ST_F0) || (r_state == ST_F1) || (r_state == ST_F2) ||
                    (r_state == ST_F3) || (r_state == ST_TAIL);

  always_comb begin
    w_idx = 3'd0;
    case (r_state)
      ST_F1:   w_idx = 3'd1;
      ST_F2:   w_idx = 3'd2;
      ST_F3:   w_idx = 3'd3;
      ST_TAIL: w_idx = {1'b1, r_tail_cnt};
      default: w_idx = 3'd0;
    endcase
  end

  combo_outp_checker u_checker (
    .clk      (clk),
    .rst      (rst),
    .i_active (w_active),
    .i_clear  (w_accept),
    .i_idx    (w_idx),
    .i_code   (r_code),
    .i_outp   (bus.outp_in),
    .o_err    (w_err)
  );

  assign bus.rsp_err = w_done && w_err;
`else
  logic w_unused_outp;
  assign w_unused_outp = bus.outp_in;
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_combo_sequencer.sv
// Self-checking bench for combo_sequencer: detector model on outp_in, rsp_err scoreboard.
module tb_combo_sequencer;

  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  combo_sequencer_if bus ();

  combo_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_vec   = 0;
  int   n_miss  = 0;
  logic sb_q[$];
  int   det_idx = -1;
  logic det_long, det_b3;
  int   det_trig = 0;
  int   exp_trig = 0;
  bit   force_at3 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:1] tb_pattern(input logic [1:0] code);
    case (code)
      2'b00:   return 3'b001;
      2'b01:   return 3'b101;
      2'b10:   return 3'b010;
      default: return 3'b110;
    endcase
  endfunction

  // Behavioural detector: triggers on nonzero b while idle, then plays the outp waveform.
  always @(negedge clk) begin
    if (det_idx >= 0) begin
      det_idx++;
      if ((det_idx == 4 && !det_long) || det_idx == 8) det_idx = -1;
    end
    if (det_idx < 0) begin
      bus.outp_in = 1'b0;
      if (bus.b != 3'b000) begin
        det_idx  = 0;
        det_long = bus.b[2];
        det_b3   = bus.b[3];
        det_trig++;
      end
    end else begin
      case (det_idx)
        2:       bus.outp_in = det_b3;
        3:       bus.outp_in = force_at3 ? 1'b0 : 1'b1;
        default: bus.outp_in = 1'b0;
      endcase
    end
  end

  // Scoreboard: every done pulse pops one expected rsp_err.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb_q.size() == 0) check("sb_unexpected_done", 1, 0);
      else check("rsp_err", bus.rsp_err, sb_q.pop_front());
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.cmd_ready, 1);
  endtask

  task automatic run_frame(input logic [1:0] code, input bit force_err, input bit hold_valid);
    logic [3:1] pat;
    int         len;
    pat = tb_pattern(code);
    len = pat[2] ? 8 : 4;
    wait_ready();
    force_at3     = force_err;
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
`ifdef COMBO_SEQUENCER_CHECK_EN
    sb_q.push_back(force_err);
`else
    sb_q.push_back(1'b0);
`endif
    exp_trig++;
    @(negedge clk);
    if (hold_valid) bus.cmd_code = ~code;
    else            bus.cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      check($sformatf("b_k%0d", i), bus.b, (i < 4) ? 32'(pat) : 32'd0);
      check($sformatf("done_early_k%0d", i), bus.done, 0);
      check($sformatf("busy_k%0d", i), bus.busy, 1);
      @(negedge clk);
    end
    check("done_at_end", bus.done, 1);
    check("b_gap", bus.b, 0);
    for (int g = 0; g < GAP; g++) begin
      check($sformatf("ready_gap%0d", g), bus.cmd_ready, 0);
      @(negedge clk);
    end
    check("ready_back", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b0;
    force_at3     = 1'b0;
  endtask

  task automatic reset_midframe();
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'b11;
    exp_trig++;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rst_pre_b", bus.b, 3'b110);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_b", bus.b, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_done", bus.done, 0);
      check("rst_idle_b", bus.b, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'b00;
    bus.outp_in   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_b", bus.b, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("reset_no_accept", bus.busy, 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.cmd_ready, 1);

    run_frame(2'b00, 1'b0, 1'b0);
    run_frame(2'b11, 1'b0, 1'b0);
    run_frame(2'b01, 1'b0, 1'b1);
    run_frame(2'b10, 1'b0, 1'b0);
    run_frame(2'b00, 1'b1, 1'b0);
    run_frame(2'b00, 1'b0, 1'b0);
    reset_midframe();
    run_frame(2'b11, 1'b0, 1'b0);
    run_frame(2'b01, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("detector_triggers", det_trig, exp_trig);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
